// File: rtl/display_pkg.sv
// Shared defaults and types for the multiplexed hex display scanner.
// The digit-index type is wide enough for up to 16 digits.
package display_pkg;

    localparam int         DIGITS_DEF   = 4;
    localparam int         PRESCALE_DEF = 50000;
    localparam int         IDX_W        = 4;
    localparam logic [6:0] SEG_BLANK    = 7'b1111111;

    typedef logic [IDX_W-1:0] digit_idx_t;

endpackage

// File: rtl/display_scan_ctrl_seg.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} glyph decoder.
// A low enable forces every segment off.
module sevenSegment
    import display_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       enable_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (enable_i) begin
            unique case (value_i)
                4'h0: seg_o = 7'b1000000;
                4'h1: seg_o = 7'b1111001;
                4'h2: seg_o = 7'b0100100;
                4'h3: seg_o = 7'b0110000;
                4'h4: seg_o = 7'b0011001;
                4'h5: seg_o = 7'b0010010;
                4'h6: seg_o = 7'b0000010;
                4'h7: seg_o = 7'b1111000;
                4'h8: seg_o = 7'b0000000;
                4'h9: seg_o = 7'b0010000;
                4'hA: seg_o = 7'b0001000;
                4'hB: seg_o = 7'b0000011;
                4'hC: seg_o = 7'b1000110;
                4'hD: seg_o = 7'b0100001;
                4'hE: seg_o = 7'b0000110;
                4'hF: seg_o = 7'b0001110;
            endcase
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed hex display scanner with a single-entry pending buffer.
// New values reach the display only at frame boundaries, so no tearing.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIGITS   = DIGITS_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS*4-1:0]   in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [6:0]            segments
);

    localparam int         CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int         DW   = DIGITS * 4;
    localparam digit_idx_t LAST = digit_idx_t'(DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [DW-1:0] disp_q, disp_d;
    logic [DW-1:0] pend_q, pend_d;
    logic          full_q, full_d;

    logic tc, frame_end, xfer;

    assign tc        = (cnt_q == CW'(PRESCALE - 1));
    assign frame_end = tc && (idx_q == LAST);
    assign in_ready  = ~full_q & ~reset;
    assign xfer      = in_valid & in_ready;

    always_comb begin
        cnt_d  = tc ? '0 : cnt_q + CW'(1);
        idx_d  = idx_q;
        disp_d = disp_q;
        pend_d = pend_q;
        full_d = full_q;
        if (tc) begin
            idx_d = (idx_q == LAST) ? '0 : idx_q + digit_idx_t'(1);
        end
        if (frame_end && full_q) begin
            disp_d = pend_q;
            full_d = 1'b0;
        end
        // Copy and load are exclusive: a transfer needs full_q low.
        if (xfer) begin
            pend_d = in_value;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    logic [3:0]        nib;
    logic [DIGITS-1:0] zero_from;
    logic              zero_sel;
    logic              run;
    logic              blank;

    // zero_from[k]: nibbles k..DIGITS-1 are all zero
    always_comb begin
        run       = 1'b1;
        zero_from = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run          = run & (disp_q[k*4 +: 4] == 4'd0);
            zero_from[k] = run;
        end
    end

    always_comb begin
        nib       = '0;
        zero_sel  = 1'b0;
        digit_sel = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == digit_idx_t'(k)) begin
                nib      = disp_q[k*4 +: 4];
                zero_sel = zero_from[k];
                if (enable) begin
                    digit_sel[k] = 1'b0;
                end
            end
        end
    end

    assign blank = blank_lz && (idx_q != '0) && zero_sel;

    sevenSegment u_seg (
        .value_i  (nib),
        .enable_i (enable & ~blank),
        .seg_o    (segments)
    );

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with PRESCALE=4, DIGITS=4.
// Accepted values queue up and are retired at model frame boundaries.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_value;
    logic        in_valid;
    logic        in_ready;
    logic        blank_lz;
    logic        enable;
    logic [3:0]  digit_sel;
    logic [6:0]  segments;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_value  (in_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .blank_lz  (blank_lz),
        .enable    (enable),
        .digit_sel (digit_sel),
        .segments  (segments)
    );

    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] sb_q[$];

    always @(posedge clk) begin
        bit rdy;
        if (reset) begin
            m_cnt  = 0;
            m_idx  = 0;
            m_disp = '0;
            sb_q.delete();
        end else begin
            rdy = (sb_q.size() == 0);
            if (m_cnt == 3 && m_idx == 3 && sb_q.size() > 0)
                m_disp = sb_q.pop_front();
            if (in_valid && rdy)
                sb_q.push_back(in_value);
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [3:0] exp_sel();
        logic [3:0] s;
        s = 4'b1111;
        if (enable) s[m_idx] = 1'b0;
        return s;
    endfunction

    function automatic logic [6:0] exp_seg();
        int h;
        h = 0;
        for (int k = 0; k < 4; k++)
            if (m_disp[k*4 +: 4] != 4'd0) h = k;
        if (!enable) return 7'h7F;
        if (blank_lz && m_idx > 0 && m_idx > h) return 7'h7F;
        return glyph(m_disp[m_idx*4 +: 4]);
    endfunction

    function automatic logic exp_rdy();
        return (sb_q.size() == 0) && !reset;
    endfunction

    task automatic send(input logic [15:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_value = v;
        while (in_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        enable   = 1'b1;
        blank_lz = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b required 0", in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (digit_sel !== 4'b1110) begin
            errors++;
            $display("FAIL reset_sel: got %b required 1110", digit_sel);
        end
        checks++;
        if (segments !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_seg: got %b required 1000000", segments);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_scan();
        logic [3:0] e;
        for (int k = 0; k < 32; k++) begin
            e = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (digit_sel !== e) begin
                errors++;
                $display("FAIL scan_c%0d: sel=%b required %b", k, digit_sel, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_transfer();
        bit got4, got1, early;
        got4  = 0;
        got1  = 0;
        early = 0;
        repeat (5) @(negedge clk);
        send(16'h1234);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL xfer_ready_drop: got %b required 0", in_ready);
        end
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (digit_sel !== exp_sel() || segments !== exp_seg() || in_ready !== exp_rdy()) begin
                errors++;
                $display("FAIL xfer_c%0d: sel=%b seg=%b rdy=%b required %b %b %b",
                         k, digit_sel, segments, in_ready, exp_sel(), exp_seg(), exp_rdy());
            end
            if (digit_sel == 4'b1110 && segments == 7'b0011001) got4 = 1;
            if (digit_sel == 4'b0111 && segments == 7'b1111001) got1 = 1;
            if (!got4 && digit_sel == 4'b0111 && segments != 7'b1000000) early = 1;
            @(negedge clk);
        end
        checks++;
        if (!(got4 && got1) || early) begin
            errors++;
            $display("FAIL xfer_glyphs: got4=%0d got1=%0d early=%0d required 1 1 0",
                     got4, got1, early);
        end
    endtask

    task automatic test_blank();
        blank_lz = 1'b1;
        send(16'h0042);
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (digit_sel !== exp_sel() || segments !== exp_seg()) begin
                errors++;
                $display("FAIL blank42_c%0d: sel=%b seg=%b required %b %b",
                         k, digit_sel, segments, exp_sel(), exp_seg());
            end
            if (m_disp == 16'h0042 && (digit_sel == 4'b0111 || digit_sel == 4'b1011)) begin
                checks++;
                if (segments !== 7'h7F) begin
                    errors++;
                    $display("FAIL blank42_lead: seg=%b required 1111111", segments);
                end
            end
            @(negedge clk);
        end
        send(16'h0000);
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (digit_sel !== exp_sel() || segments !== exp_seg()) begin
                errors++;
                $display("FAIL blank0_c%0d: sel=%b seg=%b required %b %b",
                         k, digit_sel, segments, exp_sel(), exp_seg());
            end
            if (m_disp == 16'h0000 && digit_sel != 4'b1110) begin
                checks++;
                if (segments !== 7'h7F) begin
                    errors++;
                    $display("FAIL blank0_lead: seg=%b required 1111111", segments);
                end
            end
            @(negedge clk);
        end
        while (digit_sel == 4'b1110) @(negedge clk);
        blank_lz = 1'b0;
        #1;
        checks++;
        if (segments !== 7'b1000000) begin
            errors++;
            $display("FAIL blank_off_comb: seg=%b required 1000000", segments);
        end
    endtask

    task automatic test_back_to_back();
        int n, seen_f, seen_5;
        n      = 0;
        seen_f = -1;
        seen_5 = -1;
        in_valid = 1'b1;
        in_value = 16'hBEEF;
        @(negedge clk);
        in_value = 16'hCAF5;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_drop: got %b required 0", in_ready);
        end
        while (in_ready !== 1'b1 && n < 60) begin
            checks++;
            if (in_ready !== exp_rdy() || segments !== exp_seg()) begin
                errors++;
                $display("FAIL b2b_hold_c%0d: rdy=%b seg=%b required %b %b",
                         n, in_ready, segments, exp_rdy(), exp_seg());
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL b2b_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (digit_sel !== exp_sel() || segments !== exp_seg() || in_ready !== exp_rdy()) begin
                errors++;
                $display("FAIL b2b_c%0d: sel=%b seg=%b rdy=%b required %b %b %b",
                         k, digit_sel, segments, in_ready, exp_sel(), exp_seg(), exp_rdy());
            end
            if (digit_sel == 4'b1110 && segments == 7'b0001110 && seen_f < 0) seen_f = k;
            if (digit_sel == 4'b1110 && segments == 7'b0010010 && seen_5 < 0) seen_5 = k;
            @(negedge clk);
        end
        checks++;
        if (!(seen_f >= 0 && seen_5 > seen_f)) begin
            errors++;
            $display("FAIL b2b_order: firstF=%0d first5=%0d required 0<=F<5", seen_f, seen_5);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (digit_sel !== 4'b1111 || segments !== 7'h7F) begin
                errors++;
                $display("FAIL disable_c%0d: sel=%b seg=%b required 1111 1111111",
                         k, digit_sel, segments);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (digit_sel !== exp_sel() || segments !== exp_seg()) begin
            errors++;
            $display("FAIL reenable: sel=%b seg=%b required %b %b",
                     digit_sel, segments, exp_sel(), exp_seg());
        end
    endtask

    task automatic test_reset_pending();
        bit leaked;
        leaked = 0;
        while (digit_sel != 4'b1101) @(negedge clk);
        send(16'h7777);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (digit_sel !== 4'b1110 || segments !== 7'b1000000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_pend: sel=%b seg=%b rdy=%b required 1110 1000000 1",
                     digit_sel, segments, in_ready);
        end
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (digit_sel !== exp_sel() || segments !== exp_seg() || in_ready !== exp_rdy()) begin
                errors++;
                $display("FAIL rst_pend_c%0d: sel=%b seg=%b rdy=%b required %b %b %b",
                         k, digit_sel, segments, in_ready, exp_sel(), exp_seg(), exp_rdy());
            end
            if (segments == 7'b1111000) leaked = 1;
            @(negedge clk);
        end
        checks++;
        if (leaked) begin
            errors++;
            $display("FAIL rst_pend_leak: pending glyph 7 shown, required never");
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_transfer();
        test_blank();
        test_back_to_back();
        test_enable();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
